uart_rx_sampler: RTL and testbench
==================================

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 The block SHALL have parameter DIV_W, default 8, meaning the width of the divider input.
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, meaning the number of sample ticks per bit.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port rx_bit, input, 1 bit: asynchronous serial line, idle high.
REQ-006 The block SHALL have port div, input, DIV_W bits: sample tick every div+1 clk cycles.
REQ-007 The block SHALL have port data_out, output, 8 bits: last received byte, LSB first on the line.
REQ-008 The block SHALL have port data_valid, output, 1 bit: 1-cycle pulse, drives the RX FIFO push directly.
REQ-009 The block SHALL have port frame_err, output, 1 bit: 1-cycle pulse when the stop bit samples low.
REQ-010 The block SHALL have port parity_err, output, 1 bit: 1-cycle pulse on parity mismatch; tied 0 when parity is compiled out.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 rx_bit SHALL pass through a 2-flop synchronizer before any use.
REQ-013 The tick counter SHALL count 0..div, then pulse tick for 1 cycle and wrap to 0; div=0 gives a tick every cycle.
REQ-014 A change to div SHALL take effect at the next counter wrap.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-016 In IDLE, a tick with the synced line low SHALL clear the sample count and enter START.
REQ-017 In START, at sample count 7: a low line SHALL enter DATA with the count cleared; a high line (glitch) SHALL return to IDLE with no output pulse.
REQ-018 Each bit value SHALL be the 2-of-3 majority of samples 7, 8 and 9 within the bit.
REQ-019 The bit SHALL shift in at sample 15, and the sample count SHALL wrap modulo OVERSAMPLE.
REQ-020 After the 8th data bit, the FSM SHALL enter PARITY if parity is compiled in, else STOP.
REQ-021 In STOP, at sample 8, if the stop bit is 1: data_out SHALL be updated, data_valid pulsed, and the FSM SHALL go to IDLE.
REQ-022 In STOP, at sample 8, if the stop bit is 0: frame_err SHALL pulse, data_out SHALL be held, and the FSM SHALL go to WAIT_HIGH.
REQ-023 WAIT_HIGH SHALL return to IDLE on the first tick with the synced line high.
REQ-024 A start bit arriving immediately after a stop bit SHALL be accepted.
REQ-025 data_valid, frame_err and parity_err SHALL be mutually exclusive in any cycle.
REQ-026 FIFO full SHALL NOT be checked; overflow is the FIFO's responsibility.

Reset
REQ-027 On reset, the FSM SHALL go to IDLE and the tick and sample counters SHALL clear to 0.
REQ-028 On reset, both synchronizer flops SHALL be set to 1.
REQ-029 On reset, data_out SHALL be 0x00, and data_valid, frame_err, parity_err and busy SHALL be 0.
REQ-030 Reset mid-frame SHALL discard the partial byte with no pulse.

Configuration
REQ-031 With macro UART_RX_PARITY_EN defined, a PARITY state SHALL sample one even-parity bit.
REQ-032 With the macro defined, a parity mismatch SHALL pulse parity_err at STOP sample 8 instead of data_valid, and data_out SHALL be held.
REQ-033 Without the macro, the PARITY state and its logic SHALL be absent, and parity_err SHALL be constant 0.

Structure
REQ-034 Package uart_pkg SHALL hold the FSM state encoding, OVERSAMPLE=16, MID_SAMPLE=7 and SAMPLE_BITS=4.
REQ-035 Sub-module uart_baud_tick SHALL contain the div counter and tick generator, reusable by TX.

Verification
REQ-036 div=0, frame 0x55 with 16 clk per bit, stop bit 1 -> exactly one data_valid pulse, data_out=0x55, busy low afterwards.
REQ-037 div=0, 5-clk low glitch on idle line -> START then IDLE, no data_valid, frame_err or parity_err pulse.
REQ-038 Frame 0xA5 with stop bit 0, line held low 40 clk -> one frame_err pulse, data_out unchanged, busy high until line high, then IDLE.
REQ-039 div=3, back-to-back frames 0x00 and 0xFF -> two data_valid pulses, values 0x00 then 0xFF.
REQ-040 With UART_RX_PARITY_EN defined, 0x03 sent with parity bit 1 -> one parity_err pulse, no data_valid pulse.
REQ-041 Reset asserted during bit 4 of 0x3C -> outputs return to reset values; the next clean 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM encoding, oversampling constants and a vote helper.
// StParity exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned MID_SAMPLE  = 7;
  localparam int unsigned SAMPLE_BITS = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
`ifdef UART_RX_PARITY_EN
    , StParity
`endif
  } uart_state_e;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Programmable sample-tick generator: one-cycle tick every div+1 clocks.
// div is latched at each wrap (and on reset) so a change never truncates a running period.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] lim_q, lim_d;

  always_comb begin
    tick  = (cnt_q == lim_q);
    cnt_d = cnt_q + DIV_W'(1);
    lim_d = lim_q;
    if (tick) begin
      cnt_d = '0;
      lim_d = div;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      lim_q <= div;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: 2-flop synced line, 2-of-3 vote per bit, 8 data bits, 1 stop bit.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx_sampler #(
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_bit,
  input  logic [DIV_W-1:0] div,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             parity_err,
  output logic             busy
);
  import uart_pkg::*;

  localparam logic [SAMPLE_BITS-1:0] MidIdx  = SAMPLE_BITS'(MID_SAMPLE);
  localparam logic [SAMPLE_BITS-1:0] Mid1Idx = SAMPLE_BITS'(MID_SAMPLE + 1);
  localparam logic [SAMPLE_BITS-1:0] Mid2Idx = SAMPLE_BITS'(MID_SAMPLE + 2);
  localparam logic [SAMPLE_BITS-1:0] LastIdx = SAMPLE_BITS'(OVERSAMPLE - 1);

  logic                   tick;
  logic                   sync1_q, sync2_q;
  logic                   line;
  logic                   bit_val;
  uart_state_e            state_q, state_d;
  logic [SAMPLE_BITS-1:0] scnt_q, scnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [2:0]             samp_q, samp_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [7:0]             data_out_q, data_out_d;
  logic                   dv_q, dv_d;
  logic                   fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   pe_q, pe_d;
`endif

  uart_baud_tick #(
    .DIV_W(DIV_W)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .div  (div),
    .tick (tick)
  );

  assign line    = sync2_q;
  assign bit_val = maj3(samp_q);

  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    bit_cnt_d  = bit_cnt_q;
    samp_d     = samp_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    dv_d       = 1'b0;
    fe_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    pe_d       = 1'b0;
`endif
    if (tick) begin
      scnt_d = (scnt_q == LastIdx) ? '0 : scnt_q + SAMPLE_BITS'(1);
      // Samples 7..9 feed the vote taken at the end of each bit
      if (scnt_q == MidIdx)  samp_d[0] = line;
      if (scnt_q == Mid1Idx) samp_d[1] = line;
      if (scnt_q == Mid2Idx) samp_d[2] = line;
      unique case (state_q)
        StIdle: begin
          if (!line) begin
            scnt_d    = '0;
            bit_cnt_d = '0;
            state_d   = StStart;
          end
        end
        StStart: begin
          if (scnt_q == MidIdx) begin
            scnt_d  = '0;
            state_d = line ? StIdle : StData;
          end
        end
        StData: begin
          if (scnt_q == LastIdx) begin
            shreg_d   = {bit_val, shreg_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (scnt_q == LastIdx) begin
            par_d   = bit_val;
            state_d = StStop;
          end
        end
`endif
        StStop: begin
          if (scnt_q == Mid1Idx) begin
            if (!line) begin
              fe_d    = 1'b1;
              state_d = StWaitHigh;
            end else begin
              state_d = StIdle;
`ifdef UART_RX_PARITY_EN
              if (^{shreg_q, par_q}) begin
                pe_d = 1'b1;
              end else begin
                dv_d       = 1'b1;
                data_out_d = shreg_q;
              end
`else
              dv_d       = 1'b1;
              data_out_d = shreg_q;
`endif
            end
          end
        end
        StWaitHigh: begin
          if (line) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= StIdle;
      scnt_q     <= '0;
      bit_cnt_q  <= '0;
      samp_q     <= '0;
      shreg_q    <= '0;
      data_out_q <= '0;
      dv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      sync1_q    <= rx_bit;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_q     <= samp_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      dv_q       <= dv_d;
      fe_q       <= fe_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
      pe_q  <= 1'b0;
    end else begin
      par_q <= par_d;
      pe_q  <= pe_d;
    end
  end

  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out   = data_out_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: whole-run stimulus is built up front, decoded by a tick-indexed
// frame model into per-cycle expectations, then driven and compared every cycle.
module tb_uart_rx_sampler;

  localparam int MaxC = 20000;
  localparam int MaxM = 32;
`ifdef UART_RX_PARITY_EN
  localparam int ParBits = 1;
`else
  localparam int ParBits = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_bit;
  logic [7:0] div;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx_sampler dut (
    .clk       (clk),
    .reset     (reset),
    .rx_bit    (rx_bit),
    .div       (div),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Stimulus per cycle c: inputs present before rising edge c
  bit         rx_a  [MaxC];
  bit         rst_a [MaxC];
  logic [7:0] div_a [MaxC];
  int         ncyc = 0;
  logic [7:0] cur_div = 8'd0;

  // Expected outputs just after edge c
  bit         line_a [MaxC];
  int         tk_a   [MaxC];
  bit         e_dv   [MaxC];
  bit         e_fe   [MaxC];
  bit         e_pe   [MaxC];
  bit         e_busy [MaxC];
  logic [7:0] e_byte [MaxC];
  logic [7:0] e_dout [MaxC];

  int         mk_cyc  [MaxM];
  logic [7:0] mk_dout [MaxM];
  bit         mk_busy [MaxM];
  int         mk_ndv  [MaxM];
  int         mk_nfe  [MaxM];
  int         mk_npe  [MaxM];
  int         n_mk = 0;

  int n_cmp = 0;
  int n_bad = 0;
  int cur = 0;
  bit cmp_en = 1'b0;
  int mk = 0;
  int cnt_dv = 0, cnt_fe = 0, cnt_pe = 0;

  task automatic push(input bit rx, input bit rst);
    if (ncyc < MaxC) begin
      rx_a[ncyc]  = rx;
      rst_a[ncyc] = rst;
      div_a[ncyc] = cur_div;
      ncyc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b0);
  endtask

  task automatic low(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0);
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b1);
  endtask

  task automatic mark(input logic [7:0] d, input bit b, input int ndv, input int nfe,
                      input int npe);
    if (n_mk < MaxM) begin
      mk_cyc[n_mk]  = ncyc - 1;
      mk_dout[n_mk] = d;
      mk_busy[n_mk] = b;
      mk_ndv[n_mk]  = ndv;
      mk_nfe[n_mk]  = nfe;
      mk_npe[n_mk]  = npe;
      n_mk++;
    end
  endtask

  // One frame at 16*(div+1) clocks per bit; cut>0 asserts reset after that many cycles
  task automatic frame(input logic [7:0] b, input bit stop, input bit par_ok, input int cut);
    bit bits [11];
    int nb;
    int bitclk;
    int k;
    bitclk  = 16 * (int'(cur_div) + 1);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i + 1] = b[i];
    nb = 9;
    if (ParBits == 1) begin
      bits[9] = (^b) ^ !par_ok;
      nb = 10;
    end
    bits[nb] = stop;
    nb++;
    k = 0;
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < bitclk; j++) begin
        if (cut > 0 && k == cut) begin
          rst_cycles(3);
          return;
        end
        push(bits[i], 1'b0);
        k++;
      end
    end
  endtask

  function automatic bit ln(input int k);
    return line_a[tk_a[k]];
  endfunction

  function automatic bit vote(input int base);
    int s;
    s = int'(ln(base + 7)) + int'(ln(base + 8)) + int'(ln(base + 9));
    return s >= 2;
  endfunction

  task automatic set_busy(input int from, input int upto);
    for (int c = from; c < upto; c++) e_busy[c] = 1'b1;
  endtask

  // Walk the tick list of one reset-free segment and place frame events on it
  task automatic decode(input int n, input int seg_end);
    int i, base, stop, j;
    logic [7:0] v;
    bit pbit;
    i = 0;
    while (i < n) begin
      if (ln(i)) begin
        i++;
      end else if (i + 8 >= n) begin
        set_busy(tk_a[i], seg_end);
        i = n;
      end else if (ln(i + 8)) begin
        set_busy(tk_a[i], tk_a[i + 8]);
        i = i + 9;
      end else begin
        base = i + 9;
        stop = base + 16 * (8 + ParBits) + 8;
        if (stop >= n) begin
          set_busy(tk_a[i], seg_end);
          i = n;
        end else begin
          for (int b = 0; b < 8; b++) v[b] = vote(base + 16 * b);
          pbit = (ParBits == 1) ? vote(base + 128) : 1'b0;
          if (!ln(stop)) begin
            e_fe[tk_a[stop]] = 1'b1;
            j = stop + 1;
            while (j < n && !ln(j)) j++;
            if (j >= n) begin
              set_busy(tk_a[i], seg_end);
              i = n;
            end else begin
              set_busy(tk_a[i], tk_a[j]);
              i = j + 1;
            end
          end else begin
            if (ParBits == 1 && (pbit != ^v)) begin
              e_pe[tk_a[stop]] = 1'b1;
            end else begin
              e_dv[tk_a[stop]]   = 1'b1;
              e_byte[tk_a[stop]] = v;
            end
            set_busy(tk_a[i], tk_a[stop]);
            i = stop + 1;
          end
        end
      end
    end
  endtask

  task automatic build_model();
    bit s1, s2;
    int c, r, seg_end, n, t;
    logic [7:0] d;
    s1 = 1'b1;
    s2 = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      line_a[k] = s2;
      if (rst_a[k]) begin
        s1 = 1'b1;
        s2 = 1'b1;
      end else begin
        s2 = s1;
        s1 = rx_a[k];
      end
      e_dv[k] = 1'b0; e_fe[k] = 1'b0; e_pe[k] = 1'b0; e_busy[k] = 1'b0;
      e_byte[k] = 8'h00;
    end
    c = 0;
    while (c < ncyc) begin
      if (rst_a[c]) begin
        c++;
      end else begin
        r = c - 1;
        seg_end = c;
        while (seg_end < ncyc && !rst_a[seg_end]) seg_end++;
        n = 0;
        t = r + 1 + int'(div_a[r]);
        while (t < seg_end) begin
          tk_a[n] = t;
          n++;
          t = t + 1 + int'(div_a[t]);
        end
        decode(n, seg_end);
        c = seg_end;
      end
    end
    d = 8'h00;
    for (int k = 0; k < ncyc; k++) begin
      if (rst_a[k]) d = 8'h00;
      else if (e_dv[k]) d = e_byte[k];
      e_dout[k] = d;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      n_cmp++;
      if ({data_valid, frame_err, parity_err, busy, data_out} !==
          {e_dv[cur], e_fe[cur], e_pe[cur], e_busy[cur], e_dout[cur]}) begin
        n_bad++;
        $display("FAIL cycle %0d outputs dv/fe/pe/busy/data: got %b/%b/%b/%b/%02h want %b/%b/%b/%b/%02h",
                 cur, data_valid, frame_err, parity_err, busy, data_out,
                 e_dv[cur], e_fe[cur], e_pe[cur], e_busy[cur], e_dout[cur]);
      end
      n_cmp++;
      if (int'(data_valid) + int'(frame_err) + int'(parity_err) > 1) begin
        n_bad++;
        $display("FAIL cycle %0d exclusive pulses: got dv/fe/pe %b/%b/%b want at most one",
                 cur, data_valid, frame_err, parity_err);
      end
      cnt_dv += int'(data_valid);
      cnt_fe += int'(frame_err);
      cnt_pe += int'(parity_err);
      if (mk < n_mk && mk_cyc[mk] == cur) begin
        n_cmp++;
        if (data_out !== mk_dout[mk]) begin
          n_bad++;
          $display("FAIL mark %0d data_out: got %02h want %02h", mk, data_out, mk_dout[mk]);
        end
        n_cmp++;
        if (busy !== mk_busy[mk]) begin
          n_bad++;
          $display("FAIL mark %0d busy: got %b want %b", mk, busy, mk_busy[mk]);
        end
        n_cmp++;
        if (cnt_dv != mk_ndv[mk] || cnt_fe != mk_nfe[mk] || cnt_pe != mk_npe[mk]) begin
          n_bad++;
          $display("FAIL mark %0d pulse counts dv/fe/pe: got %0d/%0d/%0d want %0d/%0d/%0d",
                   mk, cnt_dv, cnt_fe, cnt_pe, mk_ndv[mk], mk_nfe[mk], mk_npe[mk]);
        end
        cnt_dv = 0;
        cnt_fe = 0;
        cnt_pe = 0;
        mk++;
      end
    end
  end

  initial begin
    int kind;
    logic [7:0] v;

    // Reset state, then 0x55 at div=0
    cur_div = 8'd0;
    rst_cycles(4);
    mark(8'h00, 1'b0, 0, 0, 0);
    idle(40);
    frame(8'h55, 1'b1, 1'b1, 0);
    idle(40);
    mark(8'h55, 1'b0, 1, 0, 0);
    // Short glitch on the idle line
    low(5);
    idle(40);
    mark(8'h55, 1'b0, 0, 0, 0);
    // 0xA5 with a low stop bit; line low 40 clocks from the stop bit
    frame(8'hA5, 1'b0, 1'b1, 0);
    low(23);
    mark(8'h55, 1'b1, 0, 1, 0);
    low(1);
    idle(40);
    mark(8'h55, 1'b0, 0, 0, 0);
    // div=3, back-to-back 0x00 then 0xFF
    cur_div = 8'd3;
    idle(80);
    frame(8'h00, 1'b1, 1'b1, 0);
    frame(8'hFF, 1'b1, 1'b1, 0);
    idle(100);
    mark(8'hFF, 1'b0, 2, 0, 0);
`ifdef UART_RX_PARITY_EN
    cur_div = 8'd0;
    idle(20);
    frame(8'h03, 1'b1, 1'b0, 0);
    idle(40);
    mark(8'hFF, 1'b0, 0, 0, 1);
`endif
    // Reset during bit 4 of 0x3C, then a clean 0x3C
    cur_div = 8'd1;
    idle(20);
    frame(8'h3C, 1'b1, 1'b1, 5 * 32 + 16);
    idle(40);
    mark(8'h00, 1'b0, 0, 0, 0);
    frame(8'h3C, 1'b1, 1'b1, 0);
    idle(40);
    mark(8'h3C, 1'b0, 1, 0, 0);

    for (int it = 0; it < 16; it++) begin
      if (it % 4 == 0) begin
        cur_div = 8'($urandom_range(0, 2));
        idle(30);
      end
      v    = 8'($urandom);
      kind = int'($urandom_range(0, 7));
      case (kind)
        0: low(int'($urandom_range(1, 12)));
        1: begin
          frame(v, 1'b0, 1'b1, 0);
          low(int'($urandom_range(0, 30)));
        end
        2: frame(v, 1'b1, 1'b1, int'($urandom_range(1, 160 * (int'(cur_div) + 1))));
        3: frame(v, 1'b1, 1'b0, 0);
        default: frame(v, 1'b1, 1'b1, 0);
      endcase
      idle(int'($urandom_range(0, 40)));
    end
    idle(200);

    build_model();

    rx_bit = 1'b1;
    reset  = 1'b1;
    div    = 8'd0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rx_bit = rx_a[c];
      reset  = rst_a[c];
      div    = div_a[c];
      @(posedge clk);
      cur    = c;
      cmp_en = 1'b1;
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
